// File: rtl/mc_control_unit_if.sv
// Control bundle between the TSC multi-cycle sequencer (master) and the datapath/IR/memory side (slave).
interface mc_control_unit_if;
  logic [3:0] opcode;
  logic [5:0] func;
  logic       mem_ready;
  logic       branch_taken;
  logic [2:0] alu_func;
  logic [1:0] alu_src_a;
  logic [2:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       inst_done;
  logic       is_halted;

  modport master (
    input  opcode, func, mem_ready, branch_taken,
    output alu_func, alu_src_a, alu_src_b, pc_write, pc_source, i_or_d,
           mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           inst_done, is_halted
  );

  modport slave (
    output opcode, func, mem_ready, branch_taken,
    input  alu_func, alu_src_a, alu_src_b, pc_write, pc_source, i_or_d,
           mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
           inst_done, is_halted
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB/HALT sequencer for the TSC CPU; outputs are Mealy-decoded from state,
// opcode/func, mem_ready and branch_taken. mem_ready low stretches IF or MEM one cycle at a time.
module mc_control_unit (
  input  logic              clk,
  input  logic              reset_n,
  mc_control_unit_if.master ctrl
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_e;

  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_RTY = 4'd15;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_ORR = 3'd3;

  state_e state_q, state_d;

  logic is_rtype, is_rtype_alu, is_jpr, is_hlt, is_branch, is_undef;

  assign is_rtype     = (ctrl.opcode == OP_RTY);
  assign is_rtype_alu = is_rtype && (ctrl.func[5:3] == 3'd0);
  assign is_jpr       = is_rtype && (ctrl.func == 6'd25);
  assign is_hlt       = is_rtype && (ctrl.func == 6'd29);
  assign is_branch    = (ctrl.opcode <= 4'd3);
  assign is_undef     = ((ctrl.opcode >= 4'd10) && (ctrl.opcode <= 4'd14)) ||
                        (is_rtype && !is_rtype_alu && !is_jpr && !is_hlt);

  logic [2:0] alu_func, alu_src_b;
  logic [1:0] alu_src_a, pc_source;
  logic       pc_write, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, inst_done, is_halted;

  always_comb begin
    state_d    = state_q;
    alu_func   = ALU_ADD;
    alu_src_a  = 2'd0;
    alu_src_b  = 3'd0;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    inst_done  = 1'b0;
    is_halted  = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (ctrl.mem_ready) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 3'd1;
          state_d   = S_ID;
        end
      end
      S_ID: begin
        // ALU precomputes PC+sext(imm8) as the branch target regardless of opcode.
        alu_src_b = 3'd2;
        if (ctrl.opcode == OP_JMP) begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          inst_done = 1'b1;
          state_d   = S_IF;
        end else if (is_jpr) begin
          pc_write  = 1'b1;
          pc_source = 2'd3;
          inst_done = 1'b1;
          state_d   = S_IF;
        end else if (is_hlt) begin
          inst_done = 1'b1;
          state_d   = S_HALT;
        end else if (is_undef) begin
          inst_done = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d   = S_EX;
        end
      end
      S_EX: begin
        state_d = S_WB;
        if (is_rtype_alu) begin
          alu_src_a = 2'd1;
          alu_func  = ctrl.func[2:0];
        end else if (ctrl.opcode == OP_ADI) begin
          alu_src_a = 2'd1;
          alu_src_b = 3'd2;
        end else if (ctrl.opcode == OP_ORI) begin
          alu_src_a = 2'd1;
          alu_src_b = 3'd3;
          alu_func  = ALU_ORR;
        end else if (ctrl.opcode == OP_LHI) begin
          alu_src_a = 2'd2;
          alu_src_b = 3'd4;
        end else if ((ctrl.opcode == OP_LWD) || (ctrl.opcode == OP_SWD)) begin
          alu_src_a = 2'd1;
          alu_src_b = 3'd2;
          state_d   = S_MEM;
        end else if (is_branch) begin
          alu_src_a = 2'd1;
          alu_func  = ALU_SUB;
          pc_source = 2'd1;
          pc_write  = ctrl.branch_taken;
          inst_done = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d   = S_IF;
        end
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        mem_write = (ctrl.opcode == OP_SWD);
        mem_read  = (ctrl.opcode != OP_SWD);
        if (ctrl.mem_ready) begin
          if (ctrl.opcode == OP_SWD) begin
            inst_done = 1'b1;
            state_d   = S_IF;
          end else begin
            state_d   = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = (ctrl.opcode == OP_LWD);
        inst_done  = 1'b1;
        state_d    = S_IF;
      end
      S_HALT: is_halted = 1'b1;
      default: state_d = S_IF;
    endcase
    // Reset is asynchronous, so outputs must be quiet in the same cycle it asserts.
    if (!reset_n) begin
      alu_func   = 3'd0;
      alu_src_a  = 2'd0;
      alu_src_b  = 3'd0;
      pc_write   = 1'b0;
      pc_source  = 2'd0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      inst_done  = 1'b0;
      is_halted  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IF;
    else          state_q <= state_d;
  end

  assign ctrl.alu_func   = alu_func;
  assign ctrl.alu_src_a  = alu_src_a;
  assign ctrl.alu_src_b  = alu_src_b;
  assign ctrl.pc_write   = pc_write;
  assign ctrl.pc_source  = pc_source;
  assign ctrl.i_or_d     = i_or_d;
  assign ctrl.mem_read   = mem_read;
  assign ctrl.mem_write  = mem_write;
  assign ctrl.ir_write   = ir_write;
  assign ctrl.reg_write  = reg_write;
  assign ctrl.reg_dst    = reg_dst;
  assign ctrl.mem_to_reg = mem_to_reg;
  assign ctrl.inst_done  = inst_done;
  assign ctrl.is_halted  = is_halted;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed-vector bench for mc_control_unit: each vector is one clock cycle with hand-packed expected outputs.
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  mc_control_unit_if bus ();

  mc_control_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ctrl    (bus)
  );

  always #5 clk = ~clk;

  // {alu_func, src_a, src_b, pc_write, pc_source, i_or_d, mem_read, mem_write,
  //  ir_write, reg_write, reg_dst, mem_to_reg, inst_done, is_halted}
  logic [19:0] obs;
  assign obs = {bus.alu_func, bus.alu_src_a, bus.alu_src_b, bus.pc_write, bus.pc_source,
                bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.inst_done, bus.is_halted};

  function automatic logic [19:0] pk(input logic [2:0] f, input logic [1:0] a,
                                     input logic [2:0] b, input logic pw,
                                     input logic [1:0] ps, input logic iod, input logic mr,
                                     input logic mw, input logic irw, input logic rw,
                                     input logic rd, input logic m2r, input logic done,
                                     input logic hlt);
    return {f, a, b, pw, ps, iod, mr, mw, irw, rw, rd, m2r, done, hlt};
  endfunction

  task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // Apply inputs mid-cycle, check the Mealy outputs, then advance one clock.
  task automatic cyc(input string tag, input logic [3:0] op, input logic [5:0] fn,
                     input logic rdy, input logic bt, input logic [19:0] exp);
    bus.opcode       = op;
    bus.func         = fn;
    bus.mem_ready    = rdy;
    bus.branch_taken = bt;
    #1;
    chk(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  logic [19:0] v_zero, v_if_rdy, v_if_wait, v_id;

  initial begin
    v_zero    = '0;
    v_if_rdy  = pk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    v_if_wait = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    v_id      = pk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    bus.opcode = 4'd0; bus.func = 6'd0; bus.mem_ready = 1'b1; bus.branch_taken = 1'b1;
    #12;
    chk("reset_quiet", obs, v_zero);
    @(negedge clk);
    reset_n = 1'b1;

    // ADD R-type 0xF1C0
    cyc("add_if", 4'hF, 6'd0, 1, 0, v_if_rdy);
    cyc("add_id", 4'hF, 6'd0, 1, 0, v_id);
    cyc("add_ex", 4'hF, 6'd0, 1, 0, pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("add_wb", 4'hF, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));

    // LWD with two wait cycles in MEM
    cyc("lwd_if",   4'd7, 6'd0, 1, 0, v_if_rdy);
    cyc("lwd_id",   4'd7, 6'd0, 1, 0, v_id);
    cyc("lwd_ex",   4'd7, 6'd0, 1, 0, pk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwd_mem0", 4'd7, 6'd0, 0, 0, pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwd_mem1", 4'd7, 6'd0, 0, 0, pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwd_mem2", 4'd7, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc("lwd_wb",   4'd7, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));

    // BEQ taken, then not taken
    cyc("beqt_if", 4'd1, 6'd0, 1, 1, v_if_rdy);
    cyc("beqt_id", 4'd1, 6'd0, 1, 1, v_id);
    cyc("beqt_ex", 4'd1, 6'd0, 1, 1, pk(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("beqn_if", 4'd1, 6'd0, 1, 0, v_if_rdy);
    cyc("beqn_id", 4'd1, 6'd0, 1, 0, v_id);
    cyc("beqn_ex", 4'd1, 6'd0, 1, 0, pk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Fetch stalled four cycles; ID afterwards proves IF was held
    for (int i = 0; i < 4; i++) cyc("if_wait", 4'd9, 6'd0, 0, 0, v_if_wait);
    cyc("if_rdy5", 4'd9, 6'd0, 1, 0, v_if_rdy);
    cyc("jmp_id",  4'd9, 6'd0, 1, 0, pk(0, 0, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // JPR, undefined opcode, undefined func
    cyc("jpr_if",   4'hF, 6'd25, 1, 0, v_if_rdy);
    cyc("jpr_id",   4'hF, 6'd25, 1, 0, pk(0, 0, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("und_if",   4'd12, 6'd0, 1, 0, v_if_rdy);
    cyc("und_id",   4'd12, 6'd0, 1, 0, pk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    cyc("undf_if",  4'hF, 6'd8, 1, 0, v_if_rdy);
    cyc("undf_id",  4'hF, 6'd8, 1, 0, pk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // ORI, LHI, SHR execute encodings
    cyc("ori_if", 4'd5, 6'd0, 1, 0, v_if_rdy);
    cyc("ori_id", 4'd5, 6'd0, 1, 0, v_id);
    cyc("ori_ex", 4'd5, 6'd0, 1, 0, pk(3, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("ori_wb", 4'd5, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    cyc("lhi_if", 4'd6, 6'd0, 1, 0, v_if_rdy);
    cyc("lhi_id", 4'd6, 6'd0, 1, 0, v_id);
    cyc("lhi_ex", 4'd6, 6'd0, 1, 0, pk(0, 2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("lhi_wb", 4'd6, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    cyc("shr_if", 4'hF, 6'd7, 1, 0, v_if_rdy);
    cyc("shr_id", 4'hF, 6'd7, 1, 0, v_id);
    cyc("shr_ex", 4'hF, 6'd7, 1, 0, pk(7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("shr_wb", 4'hF, 6'd7, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0));

    // SWD with zero wait completes from MEM
    cyc("swd_if",  4'd8, 6'd0, 1, 0, v_if_rdy);
    cyc("swd_id",  4'd8, 6'd0, 1, 0, v_id);
    cyc("swd_ex",  4'd8, 6'd0, 1, 0, pk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("swd_mem", 4'd8, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0));

    // HLT 0xF01D, then 20 cycles of arbitrary inputs
    cyc("hlt_if", 4'hF, 6'd29, 1, 0, v_if_rdy);
    cyc("hlt_id", 4'hF, 6'd29, 1, 0, pk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 20; i++)
      cyc("halt_hold", 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    reset_n = 1'b0;
    #1;
    chk("halt_rst", obs, v_zero);
    @(negedge clk);
    reset_n = 1'b1;
    cyc("halt_refetch", 4'd4, 6'd0, 1, 0, v_if_rdy);
    cyc("adi_id",       4'd4, 6'd0, 1, 0, v_id);
    cyc("adi_ex",       4'd4, 6'd0, 1, 0, pk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc("adi_wb",       4'd4, 6'd0, 1, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0));

    // Reset asserted while SWD is stalled in MEM
    cyc("swdr_if", 4'd8, 6'd0, 1, 0, v_if_rdy);
    cyc("swdr_id", 4'd8, 6'd0, 1, 0, v_id);
    cyc("swdr_ex", 4'd8, 6'd0, 1, 0, pk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.mem_ready = 1'b0;
    #1;
    chk("swdr_mem", obs, pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    #1;
    chk("swdr_rst", obs, v_zero);
    @(posedge clk);
    #1;
    chk("swdr_rst_hold", obs, v_zero);
    reset_n = 1'b1;
    cyc("swdr_after_if",  4'd8, 6'd0, 0, 0, v_if_wait);
    cyc("swdr_after_rdy", 4'd8, 6'd0, 1, 0, v_if_rdy);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM for the 16-bit TSC CPU: it sequences fetch, decode, execute, memory and write-back. Each cycle it drives the ALU's 3-bit function code and operand selects, plus the PC, IR, register-file and memory enables. It sits between the instruction register / memory handshake and the datapath, and is the initiator side of the ALU interface.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  4  IR[15:12]; valid from ID onward
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- branch_taken  in  1  datapath branch condition, valid in EX
- alu_func  out  3  ADD=0 SUB=1 AND=2 ORR=3 NOT=4 TCP=5 SHL=6 SHR=7
- alu_src_a  out  2  0=PC, 1=rs, 2=zero
- alu_src_b  out  3  0=rt, 1=const 1, 2=sign-ext imm8, 3=zero-ext imm8, 4=imm8<<8
- pc_write  out  1  load PC
- pc_source  out  2  0=ALU result, 1=ALUOut register, 2=jump target {PC[15:12],IR[11:0]}, 3=rs
- i_or_d  out  1  0=instruction address (PC), 1=data address (ALUOut)
- mem_read, mem_write  out  1 each
- ir_write  out  1  latch the fetched word into IR
- reg_write  out  1
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- inst_done  out  1  one-cycle pulse on the final cycle of each instruction
- is_halted  out  1

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Reset state is IF.
- While reset_n is low, every output is 0.
- Outputs default to 0 in every state. Each state asserts only the signals listed below.
- IF:
  - Asserts mem_read=1 and i_or_d=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_source=0, alu_src_a=0, alu_src_b=1, alu_func=ADD (PC+1), then go to ID.
  - When mem_ready=0: stay in IF and hold ir_write=0, pc_write=0.
- ID:
  - Default work: alu_src_a=0, alu_src_b=2, alu_func=ADD. The datapath latches the branch target into ALUOut.
  - JMP (opcode 9): pc_write=1, pc_source=2, inst_done=1, go to IF.
  - JPR (opcode 15, func 25): pc_write=1, pc_source=3, inst_done=1, go to IF.
  - HLT (opcode 15, func 29): inst_done=1, go to HALT.
  - Undefined opcode/func: inst_done=1, go to IF, no writes.
  - All other instructions go to EX.
- EX, by instruction:
  - R-type ALU (opcode 15, func 0–7): src_a=1, src_b=0, alu_func=func[2:0], go to WB.
  - ADI (4): src_a=1, src_b=2, ADD, go to WB.
  - ORI (5): src_a=1, src_b=3, ORR, go to WB.
  - LHI (6): src_a=2, src_b=4, ADD, go to WB.
  - LWD (7) and SWD (8): src_a=1, src_b=2, ADD, go to MEM.
  - Branches BNE/BEQ/BGZ/BLZ (0–3): src_a=1, src_b=0, SUB, pc_source=1, pc_write=branch_taken, inst_done=1, go to IF.
- MEM:
  - Asserts i_or_d=1, plus mem_read (LWD) or mem_write (SWD).
  - Stays in MEM while mem_ready=0.
  - When mem_ready=1: LWD goes to WB; SWD asserts inst_done=1 and goes to IF.
- WB:
  - Asserts reg_write=1, reg_dst=(opcode==15), mem_to_reg=(opcode==7), inst_done=1, go to IF.
- HALT:
  - Asserts is_halted=1 and holds all other outputs at 0.
  - Only reset_n leaves HALT.

## Timing
- The state register updates on the rising edge of clk. reset_n clears it to IF asynchronously.
- Output timing:
  - Outputs are decoded combinationally from state, opcode and func.
  - pc_write, ir_write and the IF/MEM exits also depend on mem_ready and branch_taken (Mealy).
- Cycle counts with zero memory wait:
  - JMP/JPR/HLT: 2 cycles
  - Branch: 3 cycles
  - R-type, ADI, ORI, LHI: 4 cycles
  - SWD: 4 cycles
  - LWD: 5 cycles
- Each cycle that mem_ready is low adds one cycle, in IF or MEM.
- inst_done is high for exactly one cycle per instruction and is never high in IF or HALT.
- Reset mid-instruction: the FSM returns to IF immediately and no writes occur while reset_n is low. Fetch restarts on the first rising edge after release.

## Test plan
- Reset, then an ADD R-type (0xF1C0, func 0) with mem_ready=1: states IF→ID→EX→WB. In EX alu_func=0, src_a=1, src_b=0. In WB reg_write=1, reg_dst=1. inst_done pulses once in cycle 4.
- LWD (opcode 7) with mem_ready low for 2 cycles in MEM: MEM is held 3 cycles with mem_read=1, i_or_d=1. WB then has mem_to_reg=1, reg_dst=0. Total 7 cycles.
- BEQ (opcode 1), once with branch_taken=1 and once with 0: EX has alu_func=1, pc_source=1, pc_write equal to branch_taken. Each takes 3 cycles.
- IF with mem_ready held low for 4 cycles: mem_read=1 throughout, ir_write and pc_write stay 0, and the FSM stays in IF. On the 5th cycle ir_write=1 and pc_write=1.
- HLT (0xF01D): after 2 cycles is_halted=1 and stays 1 for 20 cycles under any inputs. Pulsing reset_n low clears is_halted and restarts fetch.
- reset_n asserted during the MEM state of SWD: mem_write drops to 0 in the same cycle. After release the FSM is in IF with inst_done=0.
